// File: rtl/mult_share_pkg.sv
// Shared types and widths for the multiplier-sharing arbiter.
// Optional feature macro used by the arbiter: MULT_SHARE_PIPE_EN.
package mult_share_pkg;

  localparam int OPW = 4;
  localparam int PW  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mult4x4_core.sv
// Purely combinational unsigned 4x4 -> 8 multiplier, the only arithmetic
// resource shared by all requesters.
module mult4x4_core
  import mult_share_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [PW-1:0]  p
);

  assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one 4x4 multiplier among NREQ requesters.
// Define MULT_SHARE_PIPE_EN to register operands and add a CALC cycle.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [OPW*NREQ-1:0]   req_x,
  input  logic [OPW*NREQ-1:0]   req_y,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [PW-1:0]         rsp_z
);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   ptr_nxt_s;
  logic [IDW-1:0]   cand_s;
  logic [IDW-1:0]   grant_idx_s;
  logic             found_s;
  logic             accept_s;
  logic [OPW-1:0]   gx_s;
  logic [OPW-1:0]   gy_s;
  logic [OPW-1:0]   ma_s;
  logic [OPW-1:0]   mb_s;
  logic [PW-1:0]    prod_s;
  logic             rsp_valid_r;
  logic [IDW-1:0]   rsp_id_r;
  logic [PW-1:0]    rsp_z_r;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = IDW'((int'(ptr_r) + k) % NREQ);
      if (!found_s && req_valid[cand_s]) begin
        found_s     = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        found_s     = found_s;
      end
    end
  end

  assign ptr_nxt_s = (grant_idx_s == IDW'(NREQ - 1)) ? '0 : grant_idx_s + IDW'(1'b1);
  assign gx_s      = req_x[grant_idx_s*OPW +: OPW];
  assign gy_s      = req_y[grant_idx_s*OPW +: OPW];

`ifdef MULT_SHARE_PIPE_EN
  logic [OPW-1:0] x_r;
  logic [OPW-1:0] y_r;
  assign ma_s = x_r;
  assign mb_s = y_r;
`else
  assign ma_s = gx_s;
  assign mb_s = gy_s;
`endif

  mult4x4_core u_mult (
    .a (ma_s),
    .b (mb_s),
    .p (prod_s)
  );

  // Next-state and grant decode; grants are only issued from IDLE.
  always_comb begin
    state_nxt_s = state_r;
    req_ready   = '0;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          accept_s               = 1'b1;
          req_ready[grant_idx_s] = 1'b1;
`ifdef MULT_SHARE_PIPE_EN
          state_nxt_s            = ST_CALC;
`else
          state_nxt_s            = ST_RESP;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (rsp_valid_r && rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pointer, operand capture and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r       <= '0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_z_r     <= '0;
`ifdef MULT_SHARE_PIPE_EN
      x_r         <= '0;
      y_r         <= '0;
`endif
    end else begin
      rsp_valid_r <= (state_nxt_s == ST_RESP);
      if (accept_s) begin
        ptr_r    <= ptr_nxt_s;
        rsp_id_r <= grant_idx_s;
`ifdef MULT_SHARE_PIPE_EN
        x_r      <= gx_s;
        y_r      <= gy_s;
`else
        rsp_z_r  <= prod_s;
`endif
      end
`ifdef MULT_SHARE_PIPE_EN
      // Product of the latched operands is captured on leaving CALC.
      if (state_r == ST_CALC) begin
        rsp_z_r <= prod_s;
      end
`endif
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_z     = rsp_z_r;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: scenario tasks plus a randomized
// run, checked against a round-robin pick model and plain multiplication.
module tb_mult_share_arbiter;

`ifdef MULT_SHARE_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_x;
  logic [15:0] req_y;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_z;

  int n_cmp = 0;
  int n_err = 0;
  int ptr_m = 0;

  mult_share_arbiter #(.NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_z     (rsp_z)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(logic [3:0] v, int p);
    int i;
    for (int k = 0; k < 4; k++) begin
      i = (p + k) % 4;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(int e);
    logic [3:0] r;
    r = 4'b0000;
    if (e >= 0) r[e] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] prod(logic [15:0] x, logic [15:0] y, int e);
    logic [3:0] a;
    logic [3:0] b;
    a = x[e*4 +: 4];
    b = y[e*4 +: 4];
    return 8'(a) * 8'(b);
  endfunction

  // Drives one request set with rsp_ready high and returns what was observed.
  task automatic issue(input logic [3:0] v, input logic [15:0] x, input logic [15:0] y,
                       input bit keep, output logic [3:0] rdy, output int lat,
                       output logic [1:0] id, output logic [7:0] z);
    rsp_ready = 1'b1;
    req_valid = v;
    req_x     = x;
    req_y     = y;
    #1;
    rdy = req_ready;
    step();
    if (!keep) req_valid = req_valid & ~rdy;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      step();
      lat++;
    end
    id = rsp_id;
    z  = rsp_z;
    step();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    step();
    rst_n = 1'b1;
    ptr_m = 0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_x     = 16'h0000;
    req_y     = 16'h0000;
    rsp_ready = 1'b1;
    step();
    step();
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    n_cmp++; if (rsp_z !== 8'd0) begin n_err++; $display("FAIL reset_rsp_z got=%0d exp=0", rsp_z); end
    rst_n = 1'b1;
    ptr_m = 0;
  endtask

  task automatic test_single();
    logic [3:0] rdy; int lat; logic [1:0] id; logic [7:0] z;
    issue(4'b0001, 16'h0003, 16'h0005, 1'b0, rdy, lat, id, z);
    n_cmp++; if (rdy !== 4'b0001) begin n_err++; $display("FAIL single_ready got=%b exp=0001", rdy); end
    n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL single_latency got=%0d exp=%0d", lat, LAT); end
    n_cmp++; if (id !== 2'd0) begin n_err++; $display("FAIL single_id got=%0d exp=0", id); end
    n_cmp++; if (z !== 8'd15) begin n_err++; $display("FAIL single_z got=%0d exp=15", z); end
    ptr_m = 1;
  endtask

  task automatic test_round_robin();
    logic [3:0] rdy; int lat; logic [1:0] id; logic [7:0] z;
    logic [15:0] x; logic [15:0] y; int e;
    do_reset();
    x = 16'hA3C7;
    y = 16'h5E29;
    for (int n = 0; n < 5; n++) begin
      e = pick(4'b1111, ptr_m);
      issue(4'b1111, x, y, 1'b1, rdy, lat, id, z);
      n_cmp++; if (rdy !== onehot(e) || e != n % 4) begin n_err++; $display("FAIL rr_ready[%0d] got=%b exp=%b", n, rdy, onehot(n % 4)); end
      n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL rr_latency[%0d] got=%0d exp=%0d", n, lat, LAT); end
      n_cmp++; if (id !== 2'(e)) begin n_err++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", n, id, e); end
      n_cmp++; if (z !== prod(x, y, e)) begin n_err++; $display("FAIL rr_z[%0d] got=%0d exp=%0d", n, z, prod(x, y, e)); end
      ptr_m = (e + 1) % 4;
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_skip_ptr();
    logic [3:0] rdy; int lat; logic [1:0] id; logic [7:0] z;
    int exp_order [3];
    logic [3:0] vset [3];
    exp_order = '{1, 3, 1};
    vset      = '{4'b0010, 4'b1010, 4'b1010};
    for (int n = 0; n < 3; n++) begin
      issue(vset[n], 16'h7654, 16'h2345, 1'b0, rdy, lat, id, z);
      n_cmp++; if (rdy !== onehot(exp_order[n]) || id !== 2'(exp_order[n])) begin n_err++; $display("FAIL skip_grant[%0d] got=%b/%0d exp=%0d", n, rdy, id, exp_order[n]); end
      n_cmp++; if (z !== prod(16'h7654, 16'h2345, exp_order[n])) begin n_err++; $display("FAIL skip_z[%0d] got=%0d", n, z); end
      ptr_m = (exp_order[n] + 1) % 4;
    end
  endtask

  task automatic test_corners();
    logic [3:0] rdy; int lat; logic [1:0] id; logic [7:0] z;
    issue(4'b0001, 16'h000F, 16'h000F, 1'b0, rdy, lat, id, z);
    n_cmp++; if (z !== 8'd225 || id !== 2'd0) begin n_err++; $display("FAIL max_product got=%0d id=%0d exp=225 id=0", z, id); end
    ptr_m = 1;
    issue(4'b0100, 16'h0000, 16'h0900, 1'b0, rdy, lat, id, z);
    n_cmp++; if (z !== 8'd0 || id !== 2'd2) begin n_err++; $display("FAIL zero_product got=%0d id=%0d exp=0 id=2", z, id); end
    ptr_m = 3;
  endtask

  task automatic test_stall();
    logic [1:0] id0; logic [7:0] z0; int lat; int e;
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    req_x     = 16'h0B00;
    req_y     = 16'h0D00;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL stall_grant got=%b exp=0100", req_ready); end
    step();
    ptr_m     = 3;
    req_valid = 4'b1111;
    lat = 1;
    while (!rsp_valid && lat < 8) begin step(); lat++; end
    id0 = rsp_id;
    z0  = rsp_z;
    n_cmp++; if (id0 !== 2'd2 || z0 !== 8'd143) begin n_err++; $display("FAIL stall_rsp got=%0d/%0d exp=2/143", id0, z0); end
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_id !== id0 || rsp_z !== z0 || req_ready !== 4'b0000) begin
        n_err++;
        $display("FAIL stall_hold[%0d] got v=%b id=%0d z=%0d rdy=%b exp v=1 id=%0d z=%0d rdy=0000", c, rsp_valid, rsp_id, rsp_z, req_ready, id0, z0);
      end
    end
    rsp_ready = 1'b1;
    step();
    e = pick(4'b1111, ptr_m);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL stall_release got=%b exp=0", rsp_valid); end
    n_cmp++; if (req_ready !== onehot(e)) begin n_err++; $display("FAIL stall_idle_grant got=%b exp=%b", req_ready, onehot(e)); end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_reset_midop();
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    req_x     = 16'h7000;
    req_y     = 16'h6000;
    step();
    req_valid = 4'b0000;
    rst_n     = 1'b0;
    step();
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_z !== 8'd0 || req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL midop_reset got v=%b id=%0d z=%0d rdy=%b exp all 0", rsp_valid, rsp_id, rsp_z, req_ready);
    end
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    ptr_m     = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL midop_no_rsp[%0d] got=%b exp=0", c, rsp_valid); end
    end
    req_valid = 4'b1001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL midop_restart got=%b exp=0001", req_ready); end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_random();
    logic [3:0] rdy; int lat; logic [1:0] id; logic [7:0] z;
    logic [3:0] v; logic [15:0] x; logic [15:0] y; int e;
    for (int n = 0; n < 60; n++) begin
      v = 4'($urandom_range(0, 15));
      x = 16'($urandom);
      y = 16'($urandom);
      if (v == 4'b0000) begin
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rand_idle_ready[%0d] got=%b exp=0000", n, req_ready); end
        step();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rand_idle_rsp[%0d] got=%b exp=0", n, rsp_valid); end
      end else begin
        e = pick(v, ptr_m);
        issue(v, x, y, 1'b0, rdy, lat, id, z);
        n_cmp++; if (rdy !== onehot(e)) begin n_err++; $display("FAIL rand_ready[%0d] got=%b exp=%b", n, rdy, onehot(e)); end
        n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", n, lat, LAT); end
        n_cmp++; if (id !== 2'(e) || z !== prod(x, y, e)) begin n_err++; $display("FAIL rand_rsp[%0d] got=%0d/%0d exp=%0d/%0d", n, id, z, e, prod(x, y, e)); end
        ptr_m = (e + 1) % 4;
      end
    end
    req_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_skip_ptr();
    test_corners();
    test_stall();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
